btb_predictor: RTL and testbench
================================

BTB_PREDICTOR -- requirements
Module: btb_predictor

Interface
REQ-001 Parameter ENTRIES, default 64, number of direct-mapped entries; power of two, 4..1024.
REQ-002 Parameter ADDR_WIDTH, default 26, byte-address width of all PCs.
REQ-003 Parameter IDX_W, default $clog2(ENTRIES), index width; TAG_W = ADDR_WIDTH-IDX_W-2.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 i_lookup_pc  input  ADDR_WIDTH  PC being fetched this cycle (fetch stage next-PC).
REQ-007 o_pred_taken  output  1  predicted-taken for i_lookup_pc.
REQ-008 o_pred_target  output  ADDR_WIDTH  predicted target; valid only when o_pred_taken=1.
REQ-009 i_upd_valid  input  1  resolved control-flow instruction present this cycle.
REQ-010 i_upd_pc  input  ADDR_WIDTH  PC of resolved instruction.
REQ-011 i_upd_taken  input  1  actual direction.
REQ-012 i_upd_target  input  ADDR_WIDTH  actual target.
REQ-013 i_upd_mispredict  input  1  execute stage detected misprediction (counted only).
REQ-014 i_flush_all  input  1  invalidate whole table.
REQ-015 o_hit_count  output  32  lookups with o_pred_taken=1 since reset, saturating.
REQ-016 o_mispredict_count  output  32  updates with i_upd_mispredict=1, saturating.

Function
REQ-017 Index = pc[IDX_W+1:2]; tag = pc[ADDR_WIDTH-1:IDX_W+2]; pc[1:0] ignored.
REQ-018 Each entry holds valid (1), tag (TAG_W), target (ADDR_WIDTH), 2-bit saturating counter.
REQ-019 Lookup purely combinational from current table state: hit = valid & tag match.
REQ-020 o_pred_taken = hit & counter[1]; o_pred_target = entry target when hit, else 0.
REQ-021 Update hit (valid, tag match at i_upd_pc index): counter +1 if taken (saturate 3), -1 if not taken (saturate 0).
REQ-022 Update hit with i_upd_taken=1: target overwritten with i_upd_target.
REQ-023 Update miss with i_upd_taken=1: allocate/replace entry: valid=1, tag, target written, counter=2'b10.
REQ-024 Update miss with i_upd_taken=0: table unchanged.
REQ-025 Updates take effect at the next rising edge; lookup in the same cycle as an update to the same index returns pre-update contents.
REQ-026 i_flush_all=1: all valid bits cleared at next edge; a coincident update is discarded.
REQ-027 o_hit_count increments by 1 per cycle with o_pred_taken=1; holds at 32'hFFFF_FFFF.
REQ-028 o_mispredict_count increments when i_upd_valid & i_upd_mispredict; holds at 32'hFFFF_FFFF; unaffected by flush.
REQ-029 i_upd_taken, i_upd_target, i_upd_mispredict ignored when i_upd_valid=0.

Reset
REQ-030 rst_n low: all valid bits 0, counters 2'b00, o_hit_count=0, o_mispredict_count=0, immediately (asynchronous).
REQ-031 After reset: o_pred_taken=0 and o_pred_target=0 for every lookup until first taken update.
REQ-032 Reset asserted mid-update: update lost; table fully invalid on release.
REQ-033 Tag/target storage need not be reset; only valid bits and counters.

Verification
REQ-034 After reset, lookup 0x100 -> o_pred_taken=0, o_pred_target=0.
REQ-035 Update pc=0x100 taken target=0x2000, next cycle lookup 0x100 -> taken=1, target=0x2000, o_hit_count=1 after that edge.
REQ-036 From counter=2: two not-taken updates pc=0x100 -> lookup taken=0 (counter 0); three taken updates -> counter 3, fourth taken stays 3, one not-taken -> still predicts taken.
REQ-037 ENTRIES=64: entry at 0x100 then taken update pc=0x200 (same index, different tag) -> lookup 0x100 miss, 0x200 hit target as written.
REQ-038 Update and lookup same pc same cycle on empty table -> that cycle taken=0, next cycle taken=1; i_flush_all with coincident update -> all lookups miss next cycle.
REQ-039 Force o_mispredict_count to 32'hFFFF_FFFE, apply three mispredict updates -> value 32'hFFFF_FFFF and holds.

Source files
------------

// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
// Lookup is combinational; training, allocation and flush land on the next rising edge.
module btb_predictor #(
    parameter int ENTRIES    = 64,
    parameter int ADDR_WIDTH = 26,
    parameter int IDX_W      = $clog2(ENTRIES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] i_lookup_pc,
    output logic                  o_pred_taken,
    output logic [ADDR_WIDTH-1:0] o_pred_target,
    input  logic                  i_upd_valid,
    input  logic [ADDR_WIDTH-1:0] i_upd_pc,
    input  logic                  i_upd_taken,
    input  logic [ADDR_WIDTH-1:0] i_upd_target,
    input  logic                  i_upd_mispredict,
    input  logic                  i_flush_all,
    output logic [31:0]           o_hit_count,
    output logic [31:0]           o_mispredict_count
);

    localparam int TAG_W = ADDR_WIDTH - IDX_W - 2;

    logic [ENTRIES-1:0]    r_valid;
    logic [1:0]            r_ctr    [ENTRIES];
    logic [TAG_W-1:0]      r_tag    [ENTRIES];
    logic [ADDR_WIDTH-1:0] r_target [ENTRIES];

    logic [31:0] r_hitCount;
    logic [31:0] r_mispredictCount;

    logic [IDX_W-1:0] w_lkIdx;
    logic [TAG_W-1:0] w_lkTag;
    logic             w_lkHit;
    logic [IDX_W-1:0] w_updIdx;
    logic [TAG_W-1:0] w_updTag;
    logic             w_updHit;
    logic             w_train;
    logic             w_alloc;
    logic             w_writeTarget;
    logic [1:0]       w_ctrNext;
    logic             w_unused;

    // Byte-offset bits never select anything; folding them keeps them visibly consumed.
    assign w_unused = ^{i_lookup_pc[1:0], i_upd_pc[1:0]};

    assign w_lkIdx = i_lookup_pc[IDX_W+1:2];
    assign w_lkTag = i_lookup_pc[ADDR_WIDTH-1:IDX_W+2];
    assign w_lkHit = r_valid[w_lkIdx] && (r_tag[w_lkIdx] == w_lkTag);

    assign o_pred_taken  = w_lkHit && r_ctr[w_lkIdx][1];
    assign o_pred_target = w_lkHit ? r_target[w_lkIdx] : '0;

    assign w_updIdx = i_upd_pc[IDX_W+1:2];
    assign w_updTag = i_upd_pc[ADDR_WIDTH-1:IDX_W+2];
    assign w_updHit = r_valid[w_updIdx] && (r_tag[w_updIdx] == w_updTag);

    // A flush wins over any update presented in the same cycle.
    assign w_train       = i_upd_valid && !i_flush_all && w_updHit;
    assign w_alloc       = i_upd_valid && !i_flush_all && !w_updHit && i_upd_taken;
    assign w_writeTarget = i_upd_valid && !i_flush_all && i_upd_taken;

    always_comb begin
        w_ctrNext = r_ctr[w_updIdx];
        if (i_upd_taken) begin
            if (r_ctr[w_updIdx] != 2'b11) begin
                w_ctrNext = r_ctr[w_updIdx] + 2'b01;
            end
        end else begin
            if (r_ctr[w_updIdx] != 2'b00) begin
                w_ctrNext = r_ctr[w_updIdx] - 2'b01;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_ctr[i] <= 2'b00;
            end
        end else if (i_flush_all) begin
            r_valid <= '0;
        end else if (w_train) begin
            r_ctr[w_updIdx] <= w_ctrNext;
        end else if (w_alloc) begin
            r_valid[w_updIdx] <= 1'b1;
            r_ctr[w_updIdx]   <= 2'b10;
        end
    end

    // Tag and target payload is only meaningful behind a valid bit, so it carries no reset.
    always_ff @(posedge clk) begin
        if (rst_n && w_writeTarget) begin
            r_target[w_updIdx] <= i_upd_target;
            if (w_alloc) begin
                r_tag[w_updIdx] <= w_updTag;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hitCount <= '0;
        end else if (o_pred_taken && (r_hitCount != 32'hFFFF_FFFF)) begin
            r_hitCount <= r_hitCount + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mispredictCount <= '0;
        end else if (i_upd_valid && i_upd_mispredict && (r_mispredictCount != 32'hFFFF_FFFF)) begin
            r_mispredictCount <= r_mispredictCount + 32'd1;
        end
    end

    assign o_hit_count        = r_hitCount;
    assign o_mispredict_count = r_mispredictCount;

endmodule

// File: tb/tb_btb_predictor.sv
// Self-checking bench for btb_predictor: directed scenarios plus randomized traffic
// compared against an array-based reference model of the prediction table.
module tb_btb_predictor;

    localparam int ENTRIES = 64;
    localparam int AW      = 26;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] i_lookup_pc = '0;
    logic          o_pred_taken;
    logic [AW-1:0] o_pred_target;
    logic          i_upd_valid = 1'b0;
    logic [AW-1:0] i_upd_pc = '0;
    logic          i_upd_taken = 1'b0;
    logic [AW-1:0] i_upd_target = '0;
    logic          i_upd_mispredict = 1'b0;
    logic          i_flush_all = 1'b0;
    logic [31:0]   o_hit_count;
    logic [31:0]   o_mispredict_count;

    int checksTotal = 0;
    int checksPassed = 0;

    bit            mValid  [ENTRIES];
    int unsigned   mTag    [ENTRIES];
    logic [AW-1:0] mTarget [ENTRIES];
    int            mCtr    [ENTRIES];
    logic [31:0]   mHits;
    logic [31:0]   mMisp;

    logic          obsTaken;
    logic [AW-1:0] obsTarget;
    logic          expTaken;
    logic [AW-1:0] expTarget;

    btb_predictor #(.ENTRIES(ENTRIES), .ADDR_WIDTH(AW)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .i_lookup_pc        (i_lookup_pc),
        .o_pred_taken       (o_pred_taken),
        .o_pred_target      (o_pred_target),
        .i_upd_valid        (i_upd_valid),
        .i_upd_pc           (i_upd_pc),
        .i_upd_taken        (i_upd_taken),
        .i_upd_target       (i_upd_target),
        .i_upd_mispredict   (i_upd_mispredict),
        .i_flush_all        (i_flush_all),
        .o_hit_count        (o_hit_count),
        .o_mispredict_count (o_mispredict_count)
    );

    always #5 clk = ~clk;

    function automatic int unsigned pcIndex(input logic [AW-1:0] pc);
        int unsigned v;
        v = int'(pc);
        return (v / 4) % ENTRIES;
    endfunction

    function automatic int unsigned pcTag(input logic [AW-1:0] pc);
        int unsigned v;
        v = int'(pc);
        return v / (4 * ENTRIES);
    endfunction

    task automatic modelReset();
        for (int i = 0; i < ENTRIES; i++) begin
            mValid[i] = 1'b0;
            mCtr[i]   = 0;
        end
        mHits = '0;
        mMisp = '0;
    endtask

    // Drives one cycle, samples the combinational prediction mid-cycle, then advances the model.
    task automatic driveCycle(input logic [AW-1:0] lk, input logic uv, input logic [AW-1:0] upc,
                              input logic ut, input logic [AW-1:0] utgt, input logic um,
                              input logic fl);
        int unsigned li, ui;
        bit lhit, uhit;
        i_lookup_pc      = lk;
        i_upd_valid      = uv;
        i_upd_pc         = upc;
        i_upd_taken      = ut;
        i_upd_target     = utgt;
        i_upd_mispredict = um;
        i_flush_all      = fl;
        #2;
        obsTaken  = o_pred_taken;
        obsTarget = o_pred_target;
        li   = pcIndex(lk);
        lhit = mValid[li] && (mTag[li] == pcTag(lk));
        expTaken  = lhit && (mCtr[li] >= 2);
        expTarget = lhit ? mTarget[li] : '0;
        @(posedge clk);
        if (expTaken && mHits != 32'hFFFF_FFFF) mHits = mHits + 1;
        if (uv && um && mMisp != 32'hFFFF_FFFF) mMisp = mMisp + 1;
        if (fl) begin
            for (int i = 0; i < ENTRIES; i++) mValid[i] = 1'b0;
        end else if (uv) begin
            ui   = pcIndex(upc);
            uhit = mValid[ui] && (mTag[ui] == pcTag(upc));
            if (uhit) begin
                mCtr[ui] = ut ? ((mCtr[ui] == 3) ? 3 : mCtr[ui] + 1)
                              : ((mCtr[ui] == 0) ? 0 : mCtr[ui] - 1);
                if (ut) mTarget[ui] = utgt;
            end else if (ut) begin
                mValid[ui]  = 1'b1;
                mTag[ui]    = pcTag(upc);
                mTarget[ui] = utgt;
                mCtr[ui]    = 2;
            end
        end
        #1;
    endtask

    task automatic idleLookup(input logic [AW-1:0] lk);
        driveCycle(lk, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic updateOnly(input logic [AW-1:0] upc, input logic ut, input logic [AW-1:0] utgt);
        driveCycle(26'h104, 1'b1, upc, ut, utgt, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        modelReset();
        i_lookup_pc = 26'h100;
        repeat (2) @(posedge clk);
        #1;
        checksTotal++;
        if (o_hit_count !== 32'd0) $display("[TB] FAIL reset_hit_count: got %0d expected 0", o_hit_count);
        else checksPassed++;
        checksTotal++;
        if (o_mispredict_count !== 32'd0) $display("[TB] FAIL reset_misp_count: got %0d expected 0", o_mispredict_count);
        else checksPassed++;
        rst_n = 1'b1;
        idleLookup(26'h100);
        checksTotal++;
        if (obsTaken !== 1'b0 || obsTarget !== '0)
            $display("[TB] FAIL reset_lookup: got taken=%b target=%h expected taken=0 target=0", obsTaken, obsTarget);
        else checksPassed++;
    endtask

    task automatic test_basic_alloc();
        driveCycle(26'h100, 1'b1, 26'h100, 1'b1, 26'h2000, 1'b0, 1'b0);
        checksTotal++;
        if (obsTaken !== 1'b0) $display("[TB] FAIL same_cycle_update: got taken=%b expected 0", obsTaken);
        else checksPassed++;
        idleLookup(26'h100);
        checksTotal++;
        if (obsTaken !== 1'b1 || obsTarget !== 26'h2000)
            $display("[TB] FAIL alloc_lookup: got taken=%b target=%h expected taken=1 target=2000", obsTaken, obsTarget);
        else checksPassed++;
        checksTotal++;
        if (o_hit_count !== 32'd1) $display("[TB] FAIL hit_count_first: got %0d expected 1", o_hit_count);
        else checksPassed++;
    endtask

    task automatic test_counter();
        updateOnly(26'h100, 1'b0, 26'h0);
        updateOnly(26'h100, 1'b0, 26'h0);
        idleLookup(26'h100);
        checksTotal++;
        if (obsTaken !== 1'b0 || obsTarget !== 26'h2000)
            $display("[TB] FAIL ctr_zero: got taken=%b target=%h expected taken=0 target=2000", obsTaken, obsTarget);
        else checksPassed++;
        updateOnly(26'h100, 1'b1, 26'h2000);
        updateOnly(26'h100, 1'b1, 26'h2000);
        updateOnly(26'h100, 1'b1, 26'h2400);
        idleLookup(26'h100);
        checksTotal++;
        if (obsTaken !== 1'b1 || obsTarget !== 26'h2400)
            $display("[TB] FAIL ctr_three: got taken=%b target=%h expected taken=1 target=2400", obsTaken, obsTarget);
        else checksPassed++;
        updateOnly(26'h100, 1'b1, 26'h2400);
        updateOnly(26'h100, 1'b0, 26'h0);
        idleLookup(26'h100);
        checksTotal++;
        if (obsTaken !== 1'b1) $display("[TB] FAIL ctr_saturate_high: got taken=%b expected 1", obsTaken);
        else checksPassed++;
        checksTotal++;
        if (o_hit_count !== 32'd3) $display("[TB] FAIL hit_count_counter: got %0d expected 3", o_hit_count);
        else checksPassed++;
    endtask

    task automatic test_alias();
        updateOnly(26'h200, 1'b1, 26'h3000);
        idleLookup(26'h100);
        checksTotal++;
        if (obsTaken !== 1'b0 || obsTarget !== '0)
            $display("[TB] FAIL alias_old_miss: got taken=%b target=%h expected taken=0 target=0", obsTaken, obsTarget);
        else checksPassed++;
        idleLookup(26'h200);
        checksTotal++;
        if (obsTaken !== 1'b1 || obsTarget !== 26'h3000)
            $display("[TB] FAIL alias_new_hit: got taken=%b target=%h expected taken=1 target=3000", obsTaken, obsTarget);
        else checksPassed++;
    endtask

    task automatic test_flush();
        driveCycle(26'h200, 1'b1, 26'h400, 1'b1, 26'h5000, 1'b0, 1'b1);
        checksTotal++;
        if (obsTaken !== 1'b1) $display("[TB] FAIL flush_pre_edge: got taken=%b expected 1", obsTaken);
        else checksPassed++;
        idleLookup(26'h200);
        checksTotal++;
        if (obsTaken !== 1'b0 || obsTarget !== '0)
            $display("[TB] FAIL flush_clears: got taken=%b target=%h expected taken=0 target=0", obsTaken, obsTarget);
        else checksPassed++;
        idleLookup(26'h400);
        checksTotal++;
        if (obsTaken !== 1'b0 || obsTarget !== '0)
            $display("[TB] FAIL flush_drops_update: got taken=%b target=%h expected taken=0 target=0", obsTaken, obsTarget);
        else checksPassed++;
        driveCycle(26'h500, 1'b1, 26'h500, 1'b1, 26'h6000, 1'b0, 1'b0);
        checksTotal++;
        if (obsTaken !== 1'b0) $display("[TB] FAIL empty_same_cycle: got taken=%b expected 0", obsTaken);
        else checksPassed++;
        idleLookup(26'h500);
        checksTotal++;
        if (obsTaken !== 1'b1 || obsTarget !== 26'h6000)
            $display("[TB] FAIL empty_next_cycle: got taken=%b target=%h expected taken=1 target=6000", obsTaken, obsTarget);
        else checksPassed++;
    endtask

    function automatic logic [AW-1:0] randPc();
        logic [AW-1:0] tagPart;
        logic [AW-1:0] pc;
        case ($urandom_range(0, 3))
            0:       tagPart = 26'd0;
            1:       tagPart = 26'd1;
            2:       tagPart = 26'd2;
            default: tagPart = 26'h2AAAA;
        endcase
        pc = (tagPart << 8) | (AW'($urandom_range(0, 7)) << 2) | AW'($urandom_range(0, 3));
        return pc;
    endfunction

    task automatic test_random();
        logic uv, ut, um, fl;
        for (int n = 0; n < 400; n++) begin
            uv = ($urandom_range(0, 3) != 0);
            ut = $urandom_range(0, 1) == 1;
            um = $urandom_range(0, 3) == 0;
            fl = ($urandom_range(0, 39) == 0);
            driveCycle(randPc(), uv, randPc(), ut, AW'($urandom), um, fl);
            checksTotal++;
            if (obsTaken !== expTaken) $display("[TB] FAIL rand_taken[%0d]: got %b expected %b", n, obsTaken, expTaken);
            else checksPassed++;
            checksTotal++;
            if (obsTarget !== expTarget) $display("[TB] FAIL rand_target[%0d]: got %h expected %h", n, obsTarget, expTarget);
            else checksPassed++;
            checksTotal++;
            if (o_hit_count !== mHits) $display("[TB] FAIL rand_hit_count[%0d]: got %0d expected %0d", n, o_hit_count, mHits);
            else checksPassed++;
            checksTotal++;
            if (o_mispredict_count !== mMisp)
                $display("[TB] FAIL rand_misp_count[%0d]: got %0d expected %0d", n, o_mispredict_count, mMisp);
            else checksPassed++;
        end
    endtask

    task automatic test_mispredict_saturate();
        force dut.r_mispredictCount = 32'hFFFF_FFFE;
        #1;
        release dut.r_mispredictCount;
        #1;
        mMisp = 32'hFFFF_FFFE;
        checksTotal++;
        if (o_mispredict_count !== 32'hFFFF_FFFE)
            $display("[TB] FAIL misp_preload: got %h expected fffffffe", o_mispredict_count);
        else checksPassed++;
        for (int k = 0; k < 3; k++) begin
            driveCycle(26'h104, 1'b1, 26'h900, 1'b0, 26'h0, 1'b1, 1'b0);
        end
        checksTotal++;
        if (o_mispredict_count !== 32'hFFFF_FFFF)
            $display("[TB] FAIL misp_saturate: got %h expected ffffffff", o_mispredict_count);
        else checksPassed++;
        driveCycle(26'h104, 1'b1, 26'h900, 1'b0, 26'h0, 1'b1, 1'b1);
        checksTotal++;
        if (o_mispredict_count !== 32'hFFFF_FFFF)
            $display("[TB] FAIL misp_hold: got %h expected ffffffff", o_mispredict_count);
        else checksPassed++;
    endtask

    task automatic test_reset_mid_update();
        updateOnly(26'h100, 1'b1, 26'h7000);
        i_lookup_pc  = 26'h100;
        i_upd_valid  = 1'b1;
        i_upd_pc     = 26'h700;
        i_upd_taken  = 1'b1;
        i_upd_target = 26'h7700;
        #1;
        rst_n = 1'b0;
        #1;
        checksTotal++;
        if (o_mispredict_count !== 32'd0 || o_hit_count !== 32'd0)
            $display("[TB] FAIL async_reset_counts: got hit=%0d misp=%0d expected 0 and 0", o_hit_count, o_mispredict_count);
        else checksPassed++;
        checksTotal++;
        if (o_pred_taken !== 1'b0 || o_pred_target !== '0)
            $display("[TB] FAIL async_reset_lookup: got taken=%b target=%h expected taken=0 target=0", o_pred_taken, o_pred_target);
        else checksPassed++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        modelReset();
        idleLookup(26'h700);
        checksTotal++;
        if (obsTaken !== 1'b0 || obsTarget !== '0)
            $display("[TB] FAIL reset_update_lost: got taken=%b target=%h expected taken=0 target=0", obsTaken, obsTarget);
        else checksPassed++;
        idleLookup(26'h100);
        checksTotal++;
        if (obsTaken !== 1'b0 || obsTarget !== '0)
            $display("[TB] FAIL reset_table_invalid: got taken=%b target=%h expected taken=0 target=0", obsTaken, obsTarget);
        else checksPassed++;
    endtask

    initial begin
        test_reset();
        test_basic_alloc();
        test_counter();
        test_alias();
        test_flush();
        test_random();
        test_mispredict_saturate();
        test_reset_mid_update();
        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
